mem_port_arbiter: RTL and testbench

Shares the single SRAM-like memory port between the fetch stage (instruction requester) and the memory-access stage (data requester) of the pipelined core. It grants one transaction at a time, holds the granted request stable until the memory accepts the address, and routes the response back to its owner. When a fetch is cancelled by an exception or `ertn` flush, it drops the stale instruction response.

---
 rtl/arb_pkg.sv | 29 ++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types for the fetch/memory-stage port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ADDR, DATA)
//   arb_owner_t : which requester owns the port (INST=0, DATA=1)
//   req_t       : one request bundle (wr, size, addr, wstrb, wdata)
package arb_pkg;

   localparam int unsigned ARB_ADDR_W = 32;
   localparam int unsigned ARB_DATA_W = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } arb_owner_t;

   typedef struct packed {
      logic                    wr;
      logic [1:0]              size;
      logic [ARB_ADDR_W-1:0]   addr;
      logic [ARB_DATA_W/8-1:0] wstrb;
      logic [ARB_DATA_W-1:0]   wdata;
   } req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the fetch stage (inst_*) and the
// memory-access stage (data_*). One transaction outstanding; data has fixed
// priority. The granted request is held stable until mem_addr_ok, and the
// response is routed back to its owner. A cancelled fetch has its response
// consumed from memory but not delivered.
// Ports:
//   clk, resetn (synchronous, active-low)
//   inst_*/data_* : requester side (req, wr, size, addr, wstrb, wdata in;
//                   addr_ok, data_ok, rdata out)
//   inst_cancel   : fetch in flight (or being granted) is stale
//   mem_*         : master side towards memory
// The request bundle type comes from arb_pkg; ADDR_W/DATA_W must match
// ARB_ADDR_W/ARB_DATA_W there.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ARB_ADDR_W,
   parameter int unsigned DATA_W = ARB_DATA_W
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                inst_req,
   input  logic                inst_wr,
   input  logic [1:0]          inst_size,
   input  logic [ADDR_W-1:0]   inst_addr,
   input  logic [DATA_W/8-1:0] inst_wstrb,
   input  logic [DATA_W-1:0]   inst_wdata,
   output logic                inst_addr_ok,
   output logic                inst_data_ok,
   output logic [DATA_W-1:0]   inst_rdata,
   input  logic                inst_cancel,
   input  logic                data_req,
   input  logic                data_wr,
   input  logic [1:0]          data_size,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W/8-1:0] data_wstrb,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_addr_ok,
   output logic                data_data_ok,
   output logic [DATA_W-1:0]   data_rdata,
   output logic                mem_req,
   output logic                mem_wr,
   output logic [1:0]          mem_size,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_addr_ok,
   input  logic                mem_data_ok,
   input  logic [DATA_W-1:0]   mem_rdata
);

   arb_state_t state_q, state_d;
   arb_owner_t owner_q, owner_d;
   req_t       hold_q,  hold_d;
   logic       drop_q,  drop_d;

   logic grant_data, grant_inst, grant_any;
   req_t grant_req;
   req_t mem_fields;
   logic drop_now;

   // IDLE-state grant: data wins unconditionally.
   assign grant_data = (state_q == S_IDLE) && data_req;
   assign grant_inst = (state_q == S_IDLE) && !data_req && inst_req;
   assign grant_any  = grant_data || grant_inst;

   // A cancel coinciding with the completing response also drops it.
   assign drop_now = drop_q || (inst_cancel && (owner_q == OWN_INST));

   always_comb begin
      grant_req = '0;
      if (data_req) begin
         grant_req = '{wr: data_wr, size: data_size, addr: data_addr,
                       wstrb: data_wstrb, wdata: data_wdata};
      end else begin
         grant_req = '{wr: inst_wr, size: inst_size, addr: inst_addr,
                       wstrb: inst_wstrb, wdata: inst_wdata};
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         owner_q <= OWN_INST;
         hold_q  <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         hold_q  <= hold_d;
         drop_q  <= drop_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      hold_d  = hold_q;
      drop_d  = drop_q;
      case (state_q)
         S_IDLE: begin
            drop_d = 1'b0;
            if (grant_any) begin
               hold_d  = grant_req;
               owner_d = grant_data ? OWN_DATA : OWN_INST;
               drop_d  = grant_inst && inst_cancel;
               state_d = mem_addr_ok ? S_DATA : S_ADDR;
            end
         end
         S_ADDR: begin
            drop_d = drop_now;
            if (mem_addr_ok) state_d = S_DATA;
         end
         S_DATA: begin
            drop_d = drop_now;
            if (mem_data_ok) begin
               state_d = S_IDLE;
               drop_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            drop_d  = 1'b0;
         end
      endcase
   end

   // Output logic; everything is forced low while reset is asserted.
   always_comb begin
      mem_req      = 1'b0;
      mem_fields   = '0;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = '0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = '0;
      if (resetn) begin
         case (state_q)
            S_IDLE: begin
               if (grant_any) begin
                  mem_req    = 1'b1;
                  mem_fields = grant_req;
                  if (grant_data) data_addr_ok = mem_addr_ok;
                  else            inst_addr_ok = mem_addr_ok;
               end
            end
            S_ADDR: begin
               mem_req    = 1'b1;
               mem_fields = hold_q;
               if (owner_q == OWN_DATA) data_addr_ok = mem_addr_ok;
               else                     inst_addr_ok = mem_addr_ok;
            end
            S_DATA: begin
               if (mem_data_ok) begin
                  if (owner_q == OWN_DATA) begin
                     data_data_ok = 1'b1;
                     data_rdata   = mem_rdata;
                  end else if (!drop_now) begin
                     inst_data_ok = 1'b1;
                     inst_rdata   = mem_rdata;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_wr    = mem_fields.wr;
   assign mem_size  = mem_fields.size;
   assign mem_addr  = mem_fields.addr;
   assign mem_wstrb = mem_fields.wstrb;
   assign mem_wdata = mem_fields.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Inputs change 1ns after
// the rising edge; outputs are sampled 2ns after the rising edge.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_wr, inst_cancel;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr, inst_wdata;
   logic [3:0]  inst_wstrb;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .mem_rdata(mem_rdata)
   );

   task automatic check_eq(input string tag, input logic [63:0] act,
                           input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // advance to the next cycle's input-drive point
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // let combinational outputs settle before sampling
   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0;
      inst_wstrb = '0; inst_wdata = '0; inst_cancel = 0;
      data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0;
      data_wstrb = '0; data_wdata = '0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, ".mem_req"}, 64'(mem_req), 0);
      check_eq({tag, ".mem_addr"}, 64'(mem_addr), 0);
      check_eq({tag, ".okbits"}, 64'({inst_addr_ok, inst_data_ok,
                                      data_addr_ok, data_data_ok}), 0);
      check_eq({tag, ".rdata"}, 64'({inst_rdata, data_rdata}), 0);
   endtask

   initial begin
      idle_inputs();
      resetn = 0;
      #1;
      // reset: outputs gated even with a request present
      inst_req = 1; inst_addr = 32'h1c000000;
      step(); settle();
      check_all_zero("rst_hold");
      step(); idle_inputs(); resetn = 1; settle();
      check_all_zero("rst_release");

      // inst read, no stall
      step();
      inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1; settle();
      check_eq("t1.mem_req", 64'(mem_req), 1);
      check_eq("t1.mem_addr", 64'(mem_addr), 64'h1c000000);
      check_eq("t1.mem_wr", 64'(mem_wr), 0);
      check_eq("t1.inst_addr_ok", 64'(inst_addr_ok), 1);
      check_eq("t1.data_addr_ok", 64'(data_addr_ok), 0);
      step();
      idle_inputs(); mem_data_ok = 1; mem_rdata = 32'h02800c0c; settle();
      check_eq("t1.mem_req_d", 64'(mem_req), 0);
      check_eq("t1.inst_data_ok", 64'(inst_data_ok), 1);
      check_eq("t1.inst_rdata", 64'(inst_rdata), 64'h02800c0c);
      check_eq("t1.data_side", 64'({data_data_ok, data_rdata}), 0);
      step(); idle_inputs(); settle();
      check_eq("t1.inst_rdata_idle", 64'(inst_rdata), 0);

      // simultaneous requests: data first
      inst_req = 1; inst_addr = 32'h1c000004;
      data_req = 1; data_wr = 1; data_addr = 32'h1c008000;
      data_wstrb = 4'hf; data_wdata = 32'h12345678; mem_addr_ok = 1; settle();
      check_eq("t2.mem_addr", 64'(mem_addr), 64'h1c008000);
      check_eq("t2.mem_wr", 64'(mem_wr), 1);
      check_eq("t2.mem_wstrb", 64'(mem_wstrb), 64'hf);
      check_eq("t2.mem_wdata", 64'(mem_wdata), 64'h12345678);
      check_eq("t2.data_addr_ok", 64'(data_addr_ok), 1);
      check_eq("t2.inst_addr_ok", 64'(inst_addr_ok), 0);
      step();
      data_req = 0; data_wr = 0; mem_addr_ok = 0; mem_data_ok = 1;
      mem_rdata = 32'haaaa5555; settle();
      check_eq("t2.data_data_ok", 64'(data_data_ok), 1);
      check_eq("t2.inst_data_ok", 64'(inst_data_ok), 0);
      check_eq("t2.mem_req_d", 64'(mem_req), 0);
      step();
      mem_data_ok = 0; mem_addr_ok = 1; settle();
      check_eq("t2.inst_grant", 64'({mem_req, inst_addr_ok}), 64'h3);
      check_eq("t2.inst_addr", 64'(mem_addr), 64'h1c000004);
      check_eq("t2.inst_wr", 64'(mem_wr), 0);
      step();
      idle_inputs(); mem_data_ok = 1; mem_rdata = 32'h0badf00d; settle();
      check_eq("t2.inst_rdata", 64'(inst_rdata), 64'h0badf00d);
      step(); idle_inputs();

      // address backpressure with requester changing addr
      data_req = 1; data_addr = 32'h1c000010; settle();
      check_eq("t3.c0_addr", 64'(mem_addr), 64'h1c000010);
      check_eq("t3.c0_ok", 64'(data_addr_ok), 0);
      step(); data_addr = 32'h0; mem_data_ok = 1; mem_rdata = 32'h1; settle();
      check_eq("t3.c1_addr", 64'(mem_addr), 64'h1c000010);
      check_eq("t3.c1_spurious", 64'({data_data_ok, data_addr_ok, mem_req}), 64'h1);
      step(); mem_data_ok = 0; data_req = 0; settle();
      check_eq("t3.c2_addr", 64'(mem_addr), 64'h1c000010);
      check_eq("t3.c2_req", 64'(mem_req), 1);
      step(); mem_addr_ok = 1; settle();
      check_eq("t3.c3_addr", 64'(mem_addr), 64'h1c000010);
      check_eq("t3.c3_ok", 64'(data_addr_ok), 1);
      check_eq("t3.c3_inst_ok", 64'(inst_addr_ok), 0);
      step(); idle_inputs(); mem_data_ok = 1; mem_rdata = 32'h55; settle();
      check_eq("t3.data_rdata", 64'(data_rdata), 64'h55);
      step(); idle_inputs();

      // cancel while in DATA
      inst_req = 1; inst_addr = 32'h1c000020; mem_addr_ok = 1;
      step(); idle_inputs(); inst_cancel = 1;
      step(); idle_inputs();
      step(); mem_data_ok = 1; mem_rdata = 32'hdeadbeef; settle();
      check_eq("t4.dropped", 64'(inst_data_ok), 0);
      check_eq("t4.rdata0", 64'(inst_rdata), 0);
      step(); idle_inputs(); inst_req = 1; inst_addr = 32'h1c000024;
      mem_addr_ok = 1; settle();
      check_eq("t4.regrant", 64'({mem_req, inst_addr_ok}), 64'h3);
      step(); idle_inputs(); mem_data_ok = 1; mem_rdata = 32'h11112222; settle();
      check_eq("t4.after_drop", 64'(inst_data_ok), 1);
      step(); idle_inputs();

      // cancel coinciding with response
      inst_req = 1; inst_addr = 32'h1c000030; mem_addr_ok = 1;
      step(); idle_inputs(); mem_data_ok = 1; inst_cancel = 1;
      mem_rdata = 32'h33334444; settle();
      check_eq("t5.coincide", 64'({inst_data_ok, inst_rdata}), 0);
      step(); idle_inputs();
      // cancel while data owns the port
      data_req = 1; data_addr = 32'h1c008004; mem_addr_ok = 1; inst_cancel = 1;
      step(); idle_inputs(); inst_cancel = 1; mem_data_ok = 1;
      mem_rdata = 32'hcafe0001; settle();
      check_eq("t5.data_ok", 64'(data_data_ok), 1);
      check_eq("t5.data_rdata", 64'(data_rdata), 64'hcafe0001);
      step(); idle_inputs();

      // reset while in ADDR
      inst_req = 1; inst_addr = 32'h1c000040;
      step(); inst_req = 0; settle();
      check_eq("t6.addr_req", 64'(mem_req), 1);
      resetn = 0;
      step(); settle();
      check_eq("t6.rst_req", 64'(mem_req), 0);
      resetn = 1;
      step(); settle();
      check_all_zero("t6.idle");
      data_req = 1; data_addr = 32'h1c008008; mem_addr_ok = 1; settle();
      check_eq("t6.new_grant", 64'({mem_req, data_addr_ok}), 64'h3);
      check_eq("t6.new_addr", 64'(mem_addr), 64'h1c008008);
      step(); idle_inputs(); mem_data_ok = 1; mem_rdata = 32'h77; settle();
      check_eq("t6.data_ok", 64'(data_data_ok), 1);
      step(); idle_inputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
